// File: rtl/note_pkg.sv
// Shared definitions for the note tone generator: MIDI note numbers,
// raw half-period table (in 100 MHz clock cycles) and FSM states.
package note_pkg;

  localparam logic [7:0] NOTE_REST = 8'd0;
  localparam logic [7:0] NOTE_C4   = 8'd60;
  localparam logic [7:0] NOTE_D4   = 8'd62;
  localparam logic [7:0] NOTE_E4   = 8'd64;
  localparam logic [7:0] NOTE_F4   = 8'd65;
  localparam logic [7:0] NOTE_G4   = 8'd67;
  localparam logic [7:0] NOTE_A4   = 8'd69;
  localparam logic [7:0] NOTE_B4   = 8'd71;
  localparam logic [7:0] NOTE_C5   = 8'd72;

  localparam logic [17:0] HP_C4 = 18'd191113;
  localparam logic [17:0] HP_D4 = 18'd170265;
  localparam logic [17:0] HP_E4 = 18'd151686;
  localparam logic [17:0] HP_F4 = 18'd143173;
  localparam logic [17:0] HP_G4 = 18'd127551;
  localparam logic [17:0] HP_A4 = 18'd113636;
  localparam logic [17:0] HP_B4 = 18'd101239;
  localparam logic [17:0] HP_C5 = 18'd95557;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/note_period_lut.sv
// Combinational note -> half-period lookup; rests and unsupported notes
// return zero with supported deasserted.
module note_period_lut
  import note_pkg::*;
(
  input  logic [7:0]  note,
  output logic [17:0] half_period,
  output logic        supported
);

  always_comb begin
    half_period = '0;
    supported   = 1'b0;
    case (note)
      NOTE_C4: begin half_period = HP_C4; supported = 1'b1; end
      NOTE_D4: begin half_period = HP_D4; supported = 1'b1; end
      NOTE_E4: begin half_period = HP_E4; supported = 1'b1; end
      NOTE_F4: begin half_period = HP_F4; supported = 1'b1; end
      NOTE_G4: begin half_period = HP_G4; supported = 1'b1; end
      NOTE_A4: begin half_period = HP_A4; supported = 1'b1; end
      NOTE_B4: begin half_period = HP_B4; supported = 1'b1; end
      NOTE_C5: begin half_period = HP_C5; supported = 1'b1; end
      default: begin end
    endcase
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave note player with a single pending-note slot; note changes
// only take effect at full-period boundaries so no phase is ever truncated.
module note_tone_gen
  import note_pkg::*;
#(
  parameter int HALF_SHIFT = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] note_in,
  input  logic       note_valid_in,
  output logic       note_ready_out,
  output logic       audio_out,
  output logic       playing_out,
  output logic [7:0] note_cur_out,
  output logic       bad_note_out
);

  state_t      state_q, state_d;
  logic        audio_q, audio_d;
  logic [17:0] count_q, count_d;
  logic [17:0] hp_q, hp_d;
  logic [7:0]  cur_q, cur_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_note_q, pend_note_d;
  logic [17:0] pend_hp_q, pend_hp_d;
  logic        bad_q, bad_d;

  logic [17:0] lut_hp;
  logic        lut_ok;
  logic        accept;
  logic        consume;

  // The half-period is resolved at acceptance so the pending slot already
  // carries the value to load when the note is consumed.
  note_period_lut u_lut (
    .note        (note_in),
    .half_period (lut_hp),
    .supported   (lut_ok)
  );

  assign accept = note_valid_in && !pend_valid_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      audio_q      <= 1'b0;
      count_q      <= '0;
      hp_q         <= '0;
      cur_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_note_q  <= '0;
      pend_hp_q    <= '0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      audio_q      <= audio_d;
      count_q      <= count_d;
      hp_q         <= hp_d;
      cur_q        <= cur_d;
      pend_valid_q <= pend_valid_d;
      pend_note_q  <= pend_note_d;
      pend_hp_q    <= pend_hp_d;
      bad_q        <= bad_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    audio_d      = audio_q;
    count_d      = count_q;
    hp_d         = hp_q;
    cur_d        = cur_q;
    pend_valid_d = pend_valid_q;
    pend_note_d  = pend_note_q;
    pend_hp_d    = pend_hp_q;
    bad_d        = bad_q;
    consume      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          consume = 1'b1;
          if (pend_note_q != NOTE_REST) begin
            state_d = PLAY;
            audio_d = 1'b1;
            count_d = pend_hp_q - 18'd1;
            hp_d    = pend_hp_q;
            cur_d   = pend_note_q;
          end
        end
      end
      PLAY: begin
        if (count_q != 18'd0) begin
          count_d = count_q - 18'd1;
        end else if (audio_q) begin
          audio_d = 1'b0;
          count_d = hp_q - 18'd1;
        end else if (!pend_valid_q) begin
          audio_d = 1'b1;
          count_d = hp_q - 18'd1;
        end else begin
          // End of a full period with a note waiting: switch or stop here.
          consume = 1'b1;
          if (pend_note_q != NOTE_REST) begin
            audio_d = 1'b1;
            count_d = pend_hp_q - 18'd1;
            hp_d    = pend_hp_q;
            cur_d   = pend_note_q;
          end else begin
            state_d = IDLE;
            audio_d = 1'b0;
            count_d = '0;
            hp_d    = '0;
            cur_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      pend_valid_d = 1'b0;
    end

    if (accept) begin
      pend_valid_d = 1'b1;
      pend_note_d  = lut_ok ? note_in : NOTE_REST;
      pend_hp_d    = lut_hp >> HALF_SHIFT;
      if (!lut_ok && note_in != NOTE_REST) begin
        bad_d = 1'b1;
      end
    end
  end

  assign note_ready_out = !pend_valid_q;
  assign audio_out      = audio_q;
  assign playing_out    = (state_q == PLAY);
  assign note_cur_out   = cur_q;
  assign bad_note_out   = bad_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen: an elapsed-time tone model checked
// every cycle, plus literal phase-length and flag expectations.
module tb_note_tone_gen;

  localparam int SHIFT = 10;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [7:0] note_in = 8'd0;
  logic       note_valid_in = 1'b0;
  logic       note_ready_out;
  logic       audio_out;
  logic       playing_out;
  logic [7:0] note_cur_out;
  logic       bad_note_out;

  note_tone_gen #(.HALF_SHIFT(SHIFT)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .note_in        (note_in),
    .note_valid_in  (note_valid_in),
    .note_ready_out (note_ready_out),
    .audio_out      (audio_out),
    .playing_out    (playing_out),
    .note_cur_out   (note_cur_out),
    .bad_note_out   (bad_note_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model state: a tone is described by its note, half-period and the
  // number of cycles elapsed since the current period started.
  int m_playing = 0;
  int m_note = 0;
  int m_hp = 0;
  int m_elapsed = 0;
  int m_pend = 0;
  int m_pnote = 0;
  int m_bad = 0;
  int m_acc = 0;

  function automatic int hp_of(input int n);
    case (n)
      60: return 191113 >> SHIFT;
      62: return 170265 >> SHIFT;
      64: return 151686 >> SHIFT;
      65: return 143173 >> SHIFT;
      67: return 127551 >> SHIFT;
      69: return 113636 >> SHIFT;
      71: return 101239 >> SHIFT;
      72: return 95557 >> SHIFT;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic modelStep();
    if (!rst_n_in) begin
      m_playing = 0; m_note = 0; m_hp = 0; m_elapsed = 0;
      m_pend = 0; m_pnote = 0; m_bad = 0;
    end else begin
      m_acc = (note_valid_in && m_pend == 0) ? 1 : 0;
      if (m_playing == 0) begin
        if (m_pend != 0) begin
          m_pend = 0;
          if (m_pnote != 0) begin
            m_playing = 1; m_note = m_pnote; m_hp = hp_of(m_pnote); m_elapsed = 0;
          end
        end
      end else begin
        m_elapsed++;
        if (m_elapsed == 2 * m_hp) begin
          m_elapsed = 0;
          if (m_pend != 0) begin
            m_pend = 0;
            if (m_pnote == 0) begin
              m_playing = 0; m_note = 0; m_hp = 0;
            end else begin
              m_note = m_pnote; m_hp = hp_of(m_pnote);
            end
          end
        end
      end
      if (m_acc != 0) begin
        m_pend = 1;
        m_pnote = (hp_of(int'(note_in)) != 0) ? int'(note_in) : 0;
        if (hp_of(int'(note_in)) == 0 && note_in != 8'd0) m_bad = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in or negedge rst_n_in);
    modelStep();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk_in);
    if (rst_n_in) begin
      checkOutput("cyc_audio", int'(audio_out),
                  (m_playing != 0 && m_elapsed < m_hp) ? 1 : 0);
      checkOutput("cyc_playing", int'(playing_out), m_playing);
      checkOutput("cyc_note_cur", int'(note_cur_out), (m_playing != 0) ? m_note : 0);
      checkOutput("cyc_ready", int'(note_ready_out), (m_pend == 0) ? 1 : 0);
      checkOutput("cyc_bad", int'(bad_note_out), m_bad);
    end
  end

  // Offer a note from the current negedge until it is accepted.
  task automatic applyStimulus(input logic [7:0] n);
    int waited;
    waited = 0;
    note_in = n;
    note_valid_in = 1'b1;
    while (!note_ready_out && waited < 2000) begin
      @(negedge clk_in);
      waited++;
    end
    if (waited >= 2000) checkOutput("accept_timeout", 0, 1);
    @(negedge clk_in);
    note_valid_in = 1'b0;
    note_in = 8'd0;
  endtask

  // Wait for audio_out to reach lvl, then count how many cycles it stays there.
  task automatic measurePhase(input logic lvl, output int len);
    int guard;
    guard = 0;
    len = 0;
    while (audio_out !== lvl && guard < 1000) begin
      @(negedge clk_in);
      guard++;
    end
    if (guard >= 1000) checkOutput("phase_wait_timeout", 0, 1);
    while (audio_out === lvl && len < 1000) begin
      @(negedge clk_in);
      len++;
    end
  endtask

  initial begin
    int len;
    int guard;

    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checkOutput("rst_audio", int'(audio_out), 0);
    checkOutput("rst_ready", int'(note_ready_out), 1);
    checkOutput("rst_playing", int'(playing_out), 0);
    checkOutput("rst_note_cur", int'(note_cur_out), 0);
    checkOutput("rst_bad", int'(bad_note_out), 0);

    // A4 from idle: 110-cycle phases.
    applyStimulus(8'd69);
    measurePhase(1'b1, len);
    checkOutput("a4_high_len", len, 110);
    checkOutput("a4_note_cur", int'(note_cur_out), 69);
    checkOutput("a4_playing", int'(playing_out), 1);
    measurePhase(1'b0, len);
    checkOutput("a4_low_len", len, 110);

    // C5 offered 40 cycles into an A4 high phase.
    repeat (40) @(negedge clk_in);
    applyStimulus(8'd72);
    checkOutput("chg_ready_low", int'(note_ready_out), 0);
    measurePhase(1'b0, len);
    checkOutput("chg_a4_low_len", len, 110);
    measurePhase(1'b1, len);
    checkOutput("c5_high_len", len, 93);
    checkOutput("c5_note_cur", int'(note_cur_out), 72);
    checkOutput("c5_ready_back", int'(note_ready_out), 1);

    // Same note resubmitted: phases stay intact.
    applyStimulus(8'd72);
    measurePhase(1'b0, len);
    measurePhase(1'b1, len);
    checkOutput("c5_resubmit_high_len", len, 93);

    // Switch to C4.
    applyStimulus(8'd60);
    measurePhase(1'b0, len);
    measurePhase(1'b1, len);
    checkOutput("c4_high_len", len, 186);
    checkOutput("c4_note_cur", int'(note_cur_out), 60);

    // Rest while playing: the period completes, then silence.
    applyStimulus(8'd0);
    checkOutput("rest_still_playing", int'(playing_out), 1);
    guard = 0;
    while (playing_out && guard < 1000) begin
      @(negedge clk_in);
      guard++;
    end
    checkOutput("rest_stopped", int'(playing_out), 0);
    checkOutput("rest_audio", int'(audio_out), 0);
    checkOutput("rest_note_cur", int'(note_cur_out), 0);

    // Unsupported note in idle, then a valid note still plays.
    applyStimulus(8'd61);
    repeat (3) @(negedge clk_in);
    checkOutput("bad_flag_set", int'(bad_note_out), 1);
    checkOutput("bad_audio", int'(audio_out), 0);
    checkOutput("bad_playing", int'(playing_out), 0);
    applyStimulus(8'd69);
    measurePhase(1'b1, len);
    checkOutput("post_bad_a4_high_len", len, 110);
    checkOutput("bad_flag_sticky", int'(bad_note_out), 1);
    checkOutput("post_bad_note_cur", int'(note_cur_out), 69);

    // Asynchronous reset mid-play with a note pending.
    applyStimulus(8'd72);
    checkOutput("pre_reset_pending", int'(note_ready_out), 0);
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("arst_audio", int'(audio_out), 0);
    checkOutput("arst_playing", int'(playing_out), 0);
    checkOutput("arst_note_cur", int'(note_cur_out), 0);
    checkOutput("arst_bad", int'(bad_note_out), 0);
    checkOutput("arst_ready", int'(note_ready_out), 1);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (300) @(negedge clk_in);
    checkOutput("post_rst_playing", int'(playing_out), 0);
    checkOutput("post_rst_audio", int'(audio_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
